key_dispatcher: RTL



---
 rtl/key_dispatcher.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/key_dispatcher.sv
// key_dispatcher
//   Dynamic key-space scheduler for the parallel RC4 cracking array. Idle
//   cores request fixed-size key chunks from a shared counter; chunks are
//   granted round-robin, key-space exhaustion is detected, and the first
//   successful key is latched.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start               : one-cycle pulse, begins (or restarts) a search
//   req[NUM_CORES]      : level, core i is idle and wants a chunk
//   found[NUM_CORES]    : one-cycle pulse, core i matched
//   found_key_bus       : key of core i at [i*KEY_BITS +: KEY_BITS]
//   grant               : one-hot, one-cycle grant pulse
//   chunk_base/_last    : inclusive key range of the granted chunk
//   kill                : one-cycle broadcast abort
//   busy / done         : searching / finished
//   success, winner,
//   result_key          : search outcome, valid while done
module key_dispatcher #(
    parameter int                  NUM_CORES     = 4,
    parameter int                  LOG_NUM_CORES = 2,
    parameter int                  KEY_BITS      = 24,
    parameter int                  CHUNK_LOG     = 10,
    parameter logic [KEY_BITS-1:0] KEY_MAX       = 24'h3FFFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          found,
    input  logic [NUM_CORES*KEY_BITS-1:0] found_key_bus,
    output logic [NUM_CORES-1:0]          grant,
    output logic [KEY_BITS-1:0]           chunk_base,
    output logic [KEY_BITS-1:0]           chunk_last,
    output logic                          kill,
    output logic                          busy,
    output logic                          done,
    output logic                          success,
    output logic [LOG_NUM_CORES-1:0]      winner,
    output logic [KEY_BITS-1:0]           result_key
);

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

    // One extra bit so the key counter can step past KEY_MAX without wrapping.
    localparam int               NK         = KEY_BITS + 1;
    localparam logic [NK-1:0]    CHUNK_SIZE = NK'(1) << CHUNK_LOG;
    localparam logic [NK-1:0]    KEY_MAX_X  = {1'b0, KEY_MAX};

    state_t                     state_q, state_d;
    logic [NK-1:0]              next_key_q, next_key_d;
    logic [NUM_CORES-1:0]       active_q, active_d;
    logic [LOG_NUM_CORES-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]       grant_q, grant_d;
    logic [KEY_BITS-1:0]        chunk_base_q, chunk_base_d;
    logic [KEY_BITS-1:0]        chunk_last_q, chunk_last_d;
    logic                       kill_q, kill_d;
    logic                       busy_q, done_q;
    logic                       success_q, success_d;
    logic [LOG_NUM_CORES-1:0]   winner_q, winner_d;
    logic [KEY_BITS-1:0]        result_key_q, result_key_d;

    logic                       any_found, exhausted, searching, launch, do_grant;
    logic [NUM_CORES-1:0]       eligible;
    logic                       arb_valid;
    logic [LOG_NUM_CORES-1:0]   arb_idx;
    logic [LOG_NUM_CORES-1:0]   win_idx;
    logic [KEY_BITS-1:0]        win_key;
    logic [NK-1:0]              chunk_end;

    assign any_found = |found;
    assign exhausted = next_key_q > KEY_MAX_X;
    assign searching = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    assign launch    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // The core granted last cycle still shows req; it has not seen its grant yet.
    assign eligible  = req & ~grant_q;
    assign chunk_end = next_key_q + CHUNK_SIZE - NK'(1);

    // Round-robin pick: first eligible core at or after rr_ptr.
    always_comb begin
        int c;
        // NOTE: every variable gets a default before any conditional write, so
        // no path leaves it unassigned and no latch is inferred.
        c         = 0;
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            c = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!arb_valid && eligible[c]) begin
                arb_valid = 1'b1;
                arb_idx   = LOG_NUM_CORES'(c);
            end
        end
    end

    // Lowest-index matching core wins; scan downward so the lowest is kept.
    always_comb begin
        win_idx = '0;
        win_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (found[i]) begin
                win_idx = LOG_NUM_CORES'(i);
                win_key = found_key_bus[i*KEY_BITS +: KEY_BITS];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of process ordering.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_DISPATCH;
            S_DISPATCH: if (any_found) state_d = S_DONE;
                        else if (exhausted) state_d = S_DRAIN;
            S_DRAIN:    if (any_found || (active_q == '0)) state_d = S_DONE;
            S_DONE:     if (start) state_d = S_DISPATCH;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        do_grant     = (state_q == S_DISPATCH) && !any_found && !exhausted && arb_valid;
        grant_d      = do_grant ? (NUM_CORES'(1) << arb_idx) : '0;
        chunk_base_d = do_grant ? next_key_q[KEY_BITS-1:0] : '0;
        chunk_last_d = '0;
        if (do_grant) chunk_last_d = (chunk_end > KEY_MAX_X) ? KEY_MAX : chunk_end[KEY_BITS-1:0];
        next_key_d   = do_grant ? next_key_q + CHUNK_SIZE : next_key_q;
        rr_ptr_d     = do_grant ? LOG_NUM_CORES'((int'(arb_idx) + 1) % NUM_CORES) : rr_ptr_q;
        // A core asking again has finished its chunk; a fresh grant re-arms it.
        active_d     = (active_q & ~eligible) | grant_d;
        kill_d       = 1'b0;
        success_d    = success_q;
        winner_d     = winner_q;
        result_key_d = result_key_q;

        if (launch) begin
            next_key_d   = '0;
            active_d     = '0;
            rr_ptr_d     = '0;
            success_d    = 1'b0;
            winner_d     = '0;
            result_key_d = '0;
        end

        // Success takes priority over exhaustion and over any pending grant.
        if (searching && any_found) begin
            kill_d       = 1'b1;
            success_d    = 1'b1;
            winner_d     = win_idx;
            result_key_d = win_key;
        end else if ((state_q == S_DRAIN) && (active_q == '0)) begin
            kill_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            next_key_q   <= '0;
            active_q     <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            chunk_base_q <= '0;
            chunk_last_q <= '0;
            kill_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            success_q    <= 1'b0;
            winner_q     <= '0;
            result_key_q <= '0;
        end else begin
            next_key_q   <= next_key_d;
            active_q     <= active_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            chunk_base_q <= chunk_base_d;
            chunk_last_q <= chunk_last_d;
            kill_q       <= kill_d;
            busy_q       <= (state_d == S_DISPATCH) || (state_d == S_DRAIN);
            done_q       <= (state_d == S_DONE);
            success_q    <= success_d;
            winner_q     <= winner_d;
            result_key_q <= result_key_d;
        end
    end

    assign grant      = grant_q;
    assign chunk_base = chunk_base_q;
    assign chunk_last = chunk_last_q;
    assign kill       = kill_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign winner     = winner_q;
    assign result_key = result_key_q;

endmodule
